// File: rtl/btn_cmd_queue.sv
// Button front end: synchronise, debounce and edge-detect N raw buttons, then
// queue each accepted press as a button index for the game core to pop per step.
module btn_cmd_queue #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned REPEAT_FILTER   = 1
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic [N_BTN-1:0]                           i_btn,
  input  logic                                       i_ready,
  output logic                                       o_valid,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] o_cmd,
  output logic [N_BTN-1:0]                           o_level,
  output logic [$clog2(FIFO_DEPTH):0]                o_count,
  output logic                                       o_drop
);

  localparam int unsigned IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] stable;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] press;

  logic [IW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [IW-1:0]    last_idx;

  logic [IW-1:0]    cand_idx;
  logic             have_cand;
  logic             multi;
  logic [PW-1:0]    count;
  logic [PW-1:0]    count_after;
  logic             empty;
  logic             full;
  logic             pop;
  logic             repeat_hit;
  logic             reject;
  logic             push;
  logic             drop_c;

  // Per-channel debounce completion; a press is a completion towards level 1.
  always_comb begin
    flip = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      flip[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
    press = flip & s2;
  end

  // Two-flop synchroniser and debounce counters.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt[i] <= '0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pick the lowest-index press and decide whether it is queued or dropped.
  always_comb begin
    cand_idx = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (press[i]) cand_idx = IW'(i);
    end
    have_cand   = |press;
    multi       = |(press & (press - N_BTN'(1)));
    count       = wptr - rptr;
    empty       = (count == '0);
    full        = (count == PW'(FIFO_DEPTH));
    pop         = !empty && i_ready;
    count_after = count - PW'(pop);
    repeat_hit  = (REPEAT_FILTER != 0) && (count_after != '0) && (cand_idx == last_idx);
    reject      = (full && !pop) || repeat_hit;
    push        = have_cand && !reject;
    drop_c      = multi || (have_cand && reject);
  end

  // Queue pointers, last-pushed index and drop pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wptr     <= '0;
      rptr     <= '0;
      last_idx <= '0;
      o_drop   <= 1'b0;
    end else begin
      o_drop <= drop_c;
      if (pop) rptr <= rptr + PW'(1);
      if (push) begin
        wptr     <= wptr + PW'(1);
        last_idx <= cand_idx;
      end
    end
  end

  // Queue storage; contents are only visible through the pointers.
  always_ff @(posedge i_clock) begin
    if (push) mem[wptr[AW-1:0]] <= cand_idx;
  end

  assign o_valid = !empty;
  assign o_count = count;
  assign o_level = stable;
  assign o_cmd   = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_btn_cmd_queue.sv
// Directed bench for btn_cmd_queue with a command scoreboard; a second instance
// with the repeat filter disabled is checked during the repeat-filter step.
module tb_btn_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       ready;

  logic       valid, nr_valid;
  logic [1:0] cmd, nr_cmd;
  logic [3:0] level, nr_level;
  logic [1:0] count, nr_count;
  logic       drop, nr_drop;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  btn_cmd_queue dut (
    .i_clock(clk), .i_reset(rst), .i_btn(btn), .i_ready(ready),
    .o_valid(valid), .o_cmd(cmd), .o_level(level), .o_count(count), .o_drop(drop)
  );

  btn_cmd_queue #(.REPEAT_FILTER(0)) dut_nr (
    .i_clock(clk), .i_reset(rst), .i_btn(btn), .i_ready(ready),
    .o_valid(nr_valid), .o_cmd(nr_cmd), .o_level(nr_level), .o_count(nr_count), .o_drop(nr_drop)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold one button through a full debounce, queue its expected index, release it.
  task automatic press(input int b, input bit accepted);
    btn[b] = 1'b1;
    step(6);
    if (accepted) exp_q.push_back(2'(b));
    btn[b] = 1'b0;
    step(6);
  endtask

  // Pop the head and compare it with the scoreboard.
  task automatic pop_one(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_cmd"}, 32'(cmd), 32'(e));
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 4'b1111; ready = 1'b0;
    step(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop",  32'(drop),  32'd0);

    // First press straight out of reset: six edges of latency.
    rst = 1'b0; btn = 4'b0100;
    step(5);
    chk("lat_valid_early", 32'(valid), 32'd0);
    step(1);
    chk("lat_valid", 32'(valid), 32'd1);
    chk("lat_level", 32'(level), 32'h4);
    exp_q.push_back(2'd2);
    btn = 4'b0000;
    step(6);
    chk("lat_release_level", 32'(level), 32'd0);
    pop_one("lat_pop");
    chk("lat_empty", 32'(count), 32'd0);

    // Bounce on button 1 then a clean hold.
    btn[1] = 1'b1; step(1);
    btn[1] = 1'b0; step(1);
    btn[1] = 1'b1; step(1);
    btn[1] = 1'b0; step(1);
    chk("bounce_no_push", 32'(valid), 32'd0);
    btn[1] = 1'b1;
    step(5);
    chk("bounce_early", 32'(valid), 32'd0);
    step(1);
    chk("bounce_valid", 32'(valid), 32'd1);
    exp_q.push_back(2'd1);
    btn[1] = 1'b0;
    step(6);
    pop_one("bounce_pop");

    // Queue order and full drop.
    press(3, 1'b1);
    press(0, 1'b1);
    chk("full_count", 32'(count), 32'd2);
    btn[2] = 1'b1;
    step(5);
    chk("full_drop_early", 32'(drop), 32'd0);
    step(1);
    chk("full_drop", 32'(drop), 32'd1);
    chk("full_count_hold", 32'(count), 32'd2);
    step(1);
    chk("full_drop_pulse", 32'(drop), 32'd0);
    btn[2] = 1'b0;
    step(6);
    pop_one("order_pop0");
    pop_one("order_pop1");
    chk("order_empty", 32'(valid), 32'd0);

    // Simultaneous presses: lowest index wins, the other is dropped.
    btn = 4'b1010;
    step(6);
    chk("simul_count", 32'(count), 32'd1);
    chk("simul_drop", 32'(drop), 32'd1);
    exp_q.push_back(2'd1);
    step(1);
    chk("simul_drop_pulse", 32'(drop), 32'd0);
    btn = 4'b0000;
    step(6);
    press(2, 1'b1);
    chk("fp_full", 32'(count), 32'd2);

    // Full queue, press completes on the same edge as a pop.
    btn[0] = 1'b1;
    step(5);
    chk("fp_head", 32'(cmd), 32'(exp_q.pop_front()));
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    exp_q.push_back(2'd0);
    chk("fp_no_drop", 32'(drop), 32'd0);
    chk("fp_count", 32'(count), 32'd2);
    btn[0] = 1'b0;
    step(6);
    pop_one("fp_pop0");
    pop_one("fp_pop1");
    chk("fp_empty", 32'(valid), 32'd0);

    // Repeat filter on the default instance, disabled on dut_nr.
    press(2, 1'b1);
    btn[2] = 1'b1;
    step(6);
    chk("rep_drop", 32'(drop), 32'd1);
    chk("rep_count", 32'(count), 32'd1);
    chk("rep_nr_drop", 32'(nr_drop), 32'd0);
    chk("rep_nr_count", 32'(nr_count), 32'd2);
    btn[2] = 1'b0;
    step(6);
    pop_one("rep_pop");
    chk("rep_nr_after_pop", 32'(nr_count), 32'd1);
    press(2, 1'b1);
    chk("rep_accept_drop", 32'(drop), 32'd0);
    chk("rep_accept_count", 32'(count), 32'd1);
    pop_one("rep_accept_pop");

    // Reset in the middle of a full queue and a running debounce.
    press(0, 1'b1);
    press(3, 1'b1);
    chk("mid_full", 32'(count), 32'd2);
    btn[1] = 1'b1;
    step(3);
    rst = 1'b1;
    #1;
    chk("mid_async_count", 32'(count), 32'd0);
    chk("mid_async_valid", 32'(valid), 32'd0);
    exp_q.delete();
    step(1);
    rst = 1'b0;
    step(5);
    chk("mid_requal_early", 32'(valid), 32'd0);
    step(1);
    chk("mid_requal_count", 32'(count), 32'd1);
    exp_q.push_back(2'd1);
    step(8);
    chk("mid_single", 32'(count), 32'd1);
    pop_one("mid_pop");
    chk("mid_empty", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_cmd_queue.md
Name: btn_cmd_queue

Overview:
- Parametrised successor to the direct, unconditioned button-to-game wiring used at the chip boundary.
- Conditions N raw active-high buttons: 2-FF synchroniser, per-channel debounce, rising-edge detect.
- Encodes each accepted press as a button index and buffers it in a small command FIFO. The game core pops one command per game step, so presses made between ticks are queued rather than lost.
- Sits between the chip input pins and the game core.

Parameters:
N_BTN, 4, number of button channels (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a level change is accepted (>=1)
FIFO_DEPTH, 2, command queue depth, power of two (>=2)
REPEAT_FILTER, 1, 1 = discard a press whose index equals the most recently pushed index while the queue is non-empty

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous active-high reset
i_btn  input  N_BTN  raw asynchronous buttons, active-high
i_ready  input  1  consumer pops the head entry when high and o_valid is high
o_valid  output  1  queue non-empty
o_cmd  output  max(1,$clog2(N_BTN))  index of head entry (button i -> i)
o_level  output  N_BTN  debounced button levels
o_count  output  $clog2(FIFO_DEPTH)+1  queue occupancy
o_drop  output  1  one-cycle pulse: a press was discarded

Behaviour:
- Reset (async assert, sync release): sync flops, stable levels, debounce counters, FIFO pointers and last-pushed index cleared. o_valid=0, o_cmd=0, o_level=0, o_count=0, o_drop=0.
- Synchroniser: s1<=i_btn, s2<=s1, per channel.
- Debounce, per channel:
  - s2==stable: counter<=0.
  - s2!=stable and counter<DEBOUNCE_CYCLES-1: counter increments.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable<=s2, counter<=0.
  - Any reversion before the count completes zeroes the counter.
- o_level = stable.
- Press event: stable flips 0->1 on channel i. Releases generate no command.
- Latency: input held high from before edge 1 -> stable and FIFO write at edge 2+DEBOUNCE_CYCLES -> o_valid high after that edge. Default: 6 edges.
- Simultaneous press events in one cycle: lowest index is the candidate; all other events that cycle are discarded and o_drop pulses.
- Candidate discarded, with o_drop pulsing, when:
  - the FIFO is full and no pop occurs this cycle, or
  - REPEAT_FILTER=1, o_count>0 after this cycle's pop, and the index equals the last pushed index.
- Otherwise the candidate is pushed and the last-pushed index is updated.
- Pop: o_valid&&i_ready advances the read pointer. Push and pop in the same cycle are both performed (full+pop+push stays full); o_count is unchanged.
- o_cmd = head entry, combinational from the FIFO array. o_cmd is 0 when empty.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full: pointers differ only in MSB.
  - Empty: pointers are equal.
- o_drop is a registered pulse, exactly 1 cycle per discarding cycle.
- i_reset asserted mid-operation: immediate clear of all state, including queued commands and debounce progress. Held buttons re-qualify from scratch after release of reset.

Test Plan:
- Reset: drive i_reset=1 with i_btn=4'b1111 -> o_valid=0, o_level=0, o_count=0, o_drop=0. Release and hold i_btn=4'b0100 -> o_level[2]=1 and o_valid=1 with o_cmd=2 after exactly 6 edges.
- Bounce: toggle i_btn[1] 1,0,1,0 every cycle, then hold 1 -> no push during toggling; o_cmd=1 exactly 6 edges after the final rise.
- Queue order/full: press 3, then 0, then 2 (each debounced, i_ready=0) -> o_count reaches 2 with head=3 then 0; third press gives o_drop pulse. Pop twice -> o_cmd 3 then 0, then o_valid=0.
- Simultaneous/full+pop: buttons 1 and 3 rise in the same cycle -> push 1, o_drop=1. With queue full, the press completes in the same cycle as i_ready=1 -> no drop, o_count stays 2.
- Repeat filter: REPEAT_FILTER=1, press 2 twice while the queue holds 2 -> second dropped. Pop to empty, press 2 -> accepted. REPEAT_FILTER=0 -> both accepted.
- Reset mid-op: queue holds 2 entries and a debounce is in progress; pulse i_reset -> o_count=0 immediately (async). Held button produces exactly one new command after 6 edges.
